// File: rtl/seg7_roll_reader.sv
// seg7_roll_reader: watches a 7-segment bus driven by a remote die, debounces
// it, decodes each newly settled pattern to a digit and strobes a pulse.
//
// Build option: define SEG7_READER_CHECK_EN to include the xorshift32 roll
// checker (model, snapshot, search FSM and match/mismatch counters). Without
// it, busy and both counters are tied to zero and only decode remains.
//
// Output strobes: digit_valid and invalid_pulse are single-cycle, registered
// valid-only strobes with no ready/back-pressure; a consumer must sample them
// every cycle. digit is updated in the same cycle digit_valid is high and then
// holds until the next valid accept.
module seg7_roll_reader #(
    parameter int STABLE_CYCLES = 16,
    parameter int SKIP_MAX      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    input  logic [5:0] seed,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       invalid_pulse,
    output logic       busy,
    output logic [7:0] match_count,
    output logic [7:0] mismatch_count
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_PRE = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] SEG_ZERO   = 7'h3F;

    // Input path and decode state
    logic [6:0] meta_q, meta_d;
    logic [6:0] sync_q, sync_d;
    logic [6:0] prev_q, prev_d;
    logic [6:0] last_q, last_d;
    logic [7:0] stable_cnt_q, stable_cnt_d;
    logic [3:0] digit_q, digit_d;
    logic       digit_valid_q, digit_valid_d;
    logic       invalid_pulse_q, invalid_pulse_d;

    logic       accept;
    logic       valid_accept;
    logic       dec_ok;
    logic [3:0] dec_digit;

    // Map the settled pattern back to a digit; anything unlisted is invalid
    always_comb begin
        dec_ok    = 1'b1;
        dec_digit = 4'd0;
        case (sync_q)
            7'h3F:   dec_digit = 4'd0;
            7'h06:   dec_digit = 4'd1;
            7'h5B:   dec_digit = 4'd2;
            7'h4F:   dec_digit = 4'd3;
            7'h66:   dec_digit = 4'd4;
            7'h6D:   dec_digit = 4'd5;
            7'h7C:   dec_digit = 4'd6;
            7'h07:   dec_digit = 4'd7;
            7'h7F:   dec_digit = 4'd8;
            7'h67:   dec_digit = 4'd9;
            default: dec_ok    = 1'b0;
        endcase
    end

    // Synchroniser shift, stability counter and accept decision
    always_comb begin
        meta_d = segments;
        sync_d = meta_q;
        prev_d = sync_q;

        if (sync_q != prev_q) begin
            stable_cnt_d = 8'd0;
        end else if (stable_cnt_q != STABLE_MAX) begin
            stable_cnt_d = stable_cnt_q + 8'd1;
        end else begin
            stable_cnt_d = stable_cnt_q;
        end

        // Accept fires only on the cycle the counter reaches its limit, so a
        // pattern that simply stays put is never reported twice.
        accept       = (sync_q == prev_q) && (stable_cnt_q == STABLE_PRE) &&
                       (sync_q != last_q);
        valid_accept = accept && dec_ok;

        last_d          = accept ? sync_q : last_q;
        digit_d         = valid_accept ? dec_digit : digit_q;
        digit_valid_d   = valid_accept;
        invalid_pulse_d = accept && !dec_ok;
    end

    // Register input path and decoded outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q          <= SEG_ZERO;
            sync_q          <= SEG_ZERO;
            prev_q          <= SEG_ZERO;
            last_q          <= SEG_ZERO;
            stable_cnt_q    <= 8'd0;
            digit_q         <= 4'd0;
            digit_valid_q   <= 1'b0;
            invalid_pulse_q <= 1'b0;
        end else begin
            meta_q          <= meta_d;
            sync_q          <= sync_d;
            prev_q          <= prev_d;
            last_q          <= last_d;
            stable_cnt_q    <= stable_cnt_d;
            digit_q         <= digit_d;
            digit_valid_q   <= digit_valid_d;
            invalid_pulse_q <= invalid_pulse_d;
        end
    end

    assign digit         = digit_q;
    assign digit_valid   = digit_valid_q;
    assign invalid_pulse = invalid_pulse_q;

`ifdef SEG7_READER_CHECK_EN

    localparam logic [7:0] SKIP_LAST = 8'(SKIP_MAX - 1);

    typedef enum logic [0:0] {
        CHK_IDLE   = 1'b0,
        CHK_SEARCH = 1'b1
    } chk_state_e;

    chk_state_e  chk_state_q, chk_state_d;
    logic [31:0] model_q, model_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] model_step;
    logic [7:0]  step_q, step_d;
    logic [3:0]  target_q, target_d;
    logic [7:0]  match_q, match_d;
    logic [7:0]  mis_q, mis_d;
    logic        busy_q, busy_d;

    // One xorshift32 step, identical to the transmitter's generator
    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // Candidate next model value examined in the current search step
    always_comb begin
        model_step = xs32(model_q);
    end

    // Search for the received digit within SKIP_MAX steps of the model,
    // tolerating rolls the transmitter repeated (invisible on the bus).
    always_comb begin
        chk_state_d = chk_state_q;
        model_d     = model_q;
        snap_d      = snap_q;
        step_d      = step_q;
        target_d    = target_q;
        match_d     = match_q;
        mis_d       = mis_q;

        case (chk_state_q)
            CHK_IDLE: begin
                if (valid_accept) begin
                    snap_d      = model_q;
                    step_d      = 8'd0;
                    target_d    = dec_digit;
                    chk_state_d = CHK_SEARCH;
                end
            end
            CHK_SEARCH: begin
                model_d = model_step;
                step_d  = step_q + 8'd1;
                if ((model_step[2:0] == target_q[2:0]) && (target_q <= 4'd7)) begin
                    if (match_q != 8'hFF) begin
                        match_d = match_q + 8'd1;
                    end
                    chk_state_d = CHK_IDLE;
                end else if (step_q == SKIP_LAST) begin
                    if (mis_q != 8'hFF) begin
                        mis_d = mis_q + 8'd1;
                    end
                    // A failed search must not desynchronise later rolls.
                    model_d     = snap_q;
                    chk_state_d = CHK_IDLE;
                end
            end
            default: chk_state_d = CHK_IDLE;
        endcase

        busy_d = (chk_state_d == CHK_SEARCH);
    end

    // Register checker state; the seed is reloaded for as long as reset is held
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_state_q <= CHK_IDLE;
            model_q     <= {26'b0, seed};
            snap_q      <= {26'b0, seed};
            step_q      <= 8'd0;
            target_q    <= 4'd0;
            match_q     <= 8'd0;
            mis_q       <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            chk_state_q <= chk_state_d;
            model_q     <= model_d;
            snap_q      <= snap_d;
            step_q      <= step_d;
            target_q    <= target_d;
            match_q     <= match_d;
            mis_q       <= mis_d;
            busy_q      <= busy_d;
        end
    end

    assign busy           = busy_q;
    assign match_count    = match_q;
    assign mismatch_count = mis_q;

`else

    // Checker absent: seed has no consumer and the status outputs are constant.
    logic unused_seed;
    assign unused_seed    = ^seed;
    assign busy           = 1'b0;
    assign match_count    = 8'd0;
    assign mismatch_count = 8'd0;

`endif

endmodule

// File: tb/tb_seg7_roll_reader.sv
// Bench for seg7_roll_reader: decode table vectors plus directed sequences
// for latency, debounce, checker search length and reset mid-search.
module tb_seg7_roll_reader;

    localparam int STABLE = 16;
    localparam int SKIP   = 8;
`ifdef SEG7_READER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] segments = 7'h3F;
    logic [5:0] seed = 6'd1;
    logic [3:0] digit;
    logic       digit_valid;
    logic       invalid_pulse;
    logic       busy;
    logic [7:0] match_count;
    logic [7:0] mismatch_count;

    seg7_roll_reader #(
        .STABLE_CYCLES (STABLE),
        .SKIP_MAX      (SKIP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .segments       (segments),
        .seed           (seed),
        .digit          (digit),
        .digit_valid    (digit_valid),
        .invalid_pulse  (invalid_pulse),
        .busy           (busy),
        .match_count    (match_count),
        .mismatch_count (mismatch_count)
    );

    // clock
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int vcnt  = 0;
    int icnt  = 0;
    int bcnt  = 0;

    // pulse / busy cycle counters, sampled away from the active edge
    always @(negedge clk) begin
        if (digit_valid)   vcnt++;
        if (invalid_pulse) icnt++;
        if (busy)          bcnt++;
    end

    // reference roll model
    logic [31:0] m_state;
    int          m_match;
    int          m_mis;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic model_roll(input logic [3:0] d);
        logic [31:0] snap;
        bit hit;
        snap = m_state;
        hit  = 1'b0;
        for (int n = 0; n < SKIP; n++) begin
            if (!hit) begin
                m_state = xs32(m_state);
                if ((d <= 4'd7) && (m_state[2:0] == d[2:0])) hit = 1'b1;
            end
        end
        if (hit) begin
            if (m_match < 255) m_match++;
        end else begin
            if (m_mis < 255) m_mis++;
            m_state = snap;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_counts(input string name);
        check({name, "_match"}, 32'(match_count), CHK ? 32'(m_match) : 32'd0);
        check({name, "_mismatch"}, 32'(mismatch_count), CHK ? 32'(m_mis) : 32'd0);
    endtask

    task automatic do_reset(input logic [5:0] s);
        @(negedge clk);
        reset    = 1'b1;
        seed     = s;
        segments = 7'h3F;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        m_state = {26'b0, s};
        m_match = 0;
        m_mis   = 0;
    endtask

    task automatic hold(input logic [6:0] seg, input int n);
        segments = seg;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [6:0] seg;
        int         exp_v;
        int         exp_i;
        logic [3:0] exp_d;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int v0, i0, b0, lat;
        bit seen;

        vecs[0]  = '{7'h06, 1, 0, 4'd1};
        vecs[1]  = '{7'h6D, 1, 0, 4'd5};
        vecs[2]  = '{7'h49, 0, 1, 4'd5};
        vecs[3]  = '{7'h00, 0, 1, 4'd5};
        vecs[4]  = '{7'h5B, 1, 0, 4'd2};
        vecs[5]  = '{7'h4F, 1, 0, 4'd3};
        vecs[6]  = '{7'h66, 1, 0, 4'd4};
        vecs[7]  = '{7'h7C, 1, 0, 4'd6};
        vecs[8]  = '{7'h07, 1, 0, 4'd7};
        vecs[9]  = '{7'h7F, 1, 0, 4'd8};
        vecs[10] = '{7'h67, 1, 0, 4'd9};
        vecs[11] = '{7'h3F, 1, 0, 4'd0};
        vecs[12] = '{7'h7E, 0, 1, 4'd0};
        vecs[13] = '{7'h3F, 1, 0, 4'd0};
        vecs[14] = '{7'h3F, 0, 0, 4'd0};

        // reset state, checked while reset is still asserted
        @(negedge clk);
        reset    = 1'b1;
        seed     = 6'd1;
        segments = 7'h3F;
        repeat (3) @(negedge clk);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_valid", 32'(digit_valid), 32'd0);
        check("rst_invalid", 32'(invalid_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_match", 32'(match_count), 32'd0);
        check("rst_mismatch", 32'(mismatch_count), 32'd0);
        reset   = 1'b0;
        m_state = 32'd1;
        m_match = 0;
        m_mis   = 0;

        // idle display of 0 must stay silent
        v0 = vcnt; i0 = icnt;
        hold(7'h3F, 100);
        check("idle_valid", 32'(vcnt - v0), 32'd0);
        check("idle_invalid", 32'(icnt - i0), 32'd0);
        check("idle_digit", 32'(digit), 32'd0);
        check_counts("idle");

        // decode table walk
        for (int k = 0; k < 15; k++) begin
            v0 = vcnt; i0 = icnt;
            hold(vecs[k].seg, 40);
            check($sformatf("vec%0d_valid", k), 32'(vcnt - v0), 32'(vecs[k].exp_v));
            check($sformatf("vec%0d_invalid", k), 32'(icnt - i0), 32'(vecs[k].exp_i));
            check($sformatf("vec%0d_digit", k), 32'(digit), 32'(vecs[k].exp_d));
            if (vecs[k].exp_v != 0) model_roll(vecs[k].exp_d);
            check_counts($sformatf("vec%0d", k));
        end

        // exact accept latency and single-step match
        do_reset(6'd1);
        hold(7'h3F, 5);
        v0 = vcnt; b0 = bcnt;
        segments = 7'h06;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (digit_valid) seen = 1'b1;
        end
        check("latency", 32'(lat), 32'(STABLE + 3));
        hold(7'h06, 20);
        check("lat_valid_once", 32'(vcnt - v0), 32'd1);
        check("lat_digit", 32'(digit), 32'd1);
        check("lat_busy_cycles", 32'(bcnt - b0), CHK ? 32'd1 : 32'd0);
        check("lat_match", 32'(match_count), CHK ? 32'd1 : 32'd0);

        // two-step search for 5
        b0 = bcnt;
        hold(7'h6D, 40);
        check("two_digit", 32'(digit), 32'd5);
        check("two_busy_cycles", 32'(bcnt - b0), CHK ? 32'd2 : 32'd0);
        check("two_match", 32'(match_count), CHK ? 32'd2 : 32'd0);
        check("two_mismatch", 32'(mismatch_count), 32'd0);

        // glitches shorter than the debounce window
        do_reset(6'd1);
        v0 = vcnt; i0 = icnt;
        for (int r = 0; r < 5; r++) begin
            hold(7'h06, 10);
            hold(7'h3F, 10);
        end
        hold(7'h3F, 30);
        check("glitch_valid", 32'(vcnt - v0), 32'd0);
        check("glitch_invalid", 32'(icnt - i0), 32'd0);
        check("glitch_digit", 32'(digit), 32'd0);

        // digit 8 can never match: full search, restore, next roll still matches
        do_reset(6'd1);
        v0 = vcnt; b0 = bcnt;
        hold(7'h7F, 40);
        check("eight_digit", 32'(digit), 32'd8);
        check("eight_valid", 32'(vcnt - v0), 32'd1);
        check("eight_busy_cycles", 32'(bcnt - b0), CHK ? 32'(SKIP) : 32'd0);
        check("eight_mismatch", 32'(mismatch_count), CHK ? 32'd1 : 32'd0);
        check("eight_match", 32'(match_count), 32'd0);
        b0 = bcnt;
        hold(7'h06, 40);
        check("after8_digit", 32'(digit), 32'd1);
        check("after8_busy_cycles", 32'(bcnt - b0), CHK ? 32'd1 : 32'd0);
        check("after8_match", 32'(match_count), CHK ? 32'd1 : 32'd0);
        check("after8_mismatch", 32'(mismatch_count), CHK ? 32'd1 : 32'd0);

        // reset in the middle of a search
        do_reset(6'd1);
        segments = 7'h7F;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!seen) begin
                @(negedge clk);
                if (digit_valid) seen = 1'b1;
            end
        end
        check("mid_accept_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        check("mid_busy_before", 32'(busy), CHK ? 32'd1 : 32'd0);
        reset    = 1'b1;
        segments = 7'h06;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_digit", 32'(digit), 32'd0);
        check("mid_rst_mismatch", 32'(mismatch_count), 32'd0);
        reset = 1'b0;
        hold(7'h06, 40);
        check("mid_after_digit", 32'(digit), 32'd1);
        check("mid_after_match", 32'(match_count), CHK ? 32'd1 : 32'd0);
        check("mid_after_mismatch", 32'(mismatch_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
